// File: rtl/comp_link_pkg.sv
// comp_link_pkg: shared constants, state type and header test for the comparator trigger link receiver
package comp_link_pkg;
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [1:0] HDR_ISK = 2'b01;
  localparam int FRM_WORDS = 4;
  localparam int PH_W = $clog2(FRM_WORDS);
  typedef enum logic [1:0] {HUNT, CHK, LOCKED} sync_state_t;
  function automatic logic is_header(input logic [15:0] data, input logic [1:0] isk, input logic [1:0] code_err);
    return isk == HDR_ISK && data[7:0] == K28_5 && code_err == 2'b00;
  endfunction
endpackage

// File: rtl/comp_link_sync_fsm.sv
// comp_link_sync_fsm: frame alignment FSM (HUNT/CHK/LOCKED) with word-phase counter and phase strobes
module comp_link_sync_fsm
  import comp_link_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 hdr,
  output logic [PH_W-1:0]      phase,
  output logic                 sync_done,
  output logic [FRM_WORDS-1:0] cew
);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);
  sync_state_t state, state_n;
  logic [PH_W-1:0] phase_n;
  logic [GW-1:0] good, good_n, good_inc;
  logic [BW-1:0] bad, bad_n, bad_inc;
  assign good_inc = good + GW'(1);
  assign bad_inc = bad + BW'(1);
  assign sync_done = state == LOCKED;
  assign cew = sync_done ? FRM_WORDS'(1) << phase : '0;
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= HUNT;
      phase <= '0;
      good <= '0;
      bad <= '0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      good <= good_n;
      bad <= bad_n;
    end
  end
  // in HUNT the header just seen is phase 0, so the next word is phase 1
  always_comb begin
    state_n = state;
    good_n = good;
    bad_n = bad;
    phase_n = state == HUNT ? (hdr ? PH_W'(1) : '0) : phase + PH_W'(1);
    case (state)
      HUNT: if (hdr) begin
        good_n = GW'(1);
        bad_n = '0;
        state_n = LOCK_CNT == 1 ? LOCKED : CHK;
      end
      CHK: if (phase == '0) begin
        good_n = hdr ? good_inc : '0;
        bad_n = '0;
        state_n = !hdr ? HUNT : good_inc == GW'(LOCK_CNT) ? LOCKED : CHK;
      end
      LOCKED: if (phase == '0) begin
        bad_n = hdr ? '0 : bad_inc;
        state_n = !hdr && bad_inc == BW'(UNLOCK_CNT) ? HUNT : LOCKED;
      end
      default: state_n = HUNT;
    endcase
  end
endmodule

// File: rtl/comp_frame_decoder.sv
// comp_frame_decoder: comparator link RX decoder - frame alignment, 48-bit data rebuild, error stats.
// Optional sequence continuity check enabled by defining FRAME_SEQ_CHECK_EN.
module comp_frame_decoder
  import comp_link_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic [15:0]          rx_data,
  input  logic [1:0]           rx_isk,
  input  logic [1:0]           rx_code_err,
  input  logic                 clr_err,
  output logic                 sync_done,
  output logic                 cew0,
  output logic                 cew1,
  output logic                 cew2,
  output logic                 cew3,
  output logic                 valid,
  output logic [47:0]          rcv_data,
  output logic [7:0]           frm_seq,
  output logic                 bad_frm,
  output logic                 seq_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);
  logic [15:0] r_data, g12, g34;
  logic [1:0] r_isk, r_cerr;
  logic [7:0] seq_cap;
  logic [PH_W-1:0] phase;
  logic [FRM_WORDS-1:0] cew;
  logic hdr, hdr_ok, live, cerr_acc, isk_acc;
  logic first, last, frm_live, frm_cerr, frm_isk, good, mis, err_inc;
  assign hdr = is_header(r_data, r_isk, r_cerr);
  assign {cew3, cew2, cew1, cew0} = cew;
  comp_link_sync_fsm #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT)) u_sync (
    .clk(clk), .rst_b(rst_b), .hdr(hdr), .phase(phase), .sync_done(sync_done), .cew(cew)
  );
  assign first = phase == '0;
  assign last = phase == PH_W'(FRM_WORDS - 1);
  assign frm_live = live & sync_done;
  assign frm_cerr = cerr_acc | (|r_cerr);
  assign frm_isk = isk_acc | (|r_isk);
  assign good = last & frm_live & hdr_ok & !frm_cerr & !frm_isk;
  // bad headers count as they arrive so the header that drops lock is still counted
  assign err_inc = (sync_done & first & !hdr) | (last & frm_live & hdr_ok & (frm_cerr | (good & mis)));
`ifdef FRAME_SEQ_CHECK_EN
  logic ref_vld;
  logic [7:0] seq_ref;
  assign mis = ref_vld && seq_cap != seq_ref + 8'd1;
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ref_vld <= 1'b0;
      seq_ref <= '0;
    end else if (!sync_done) begin
      ref_vld <= 1'b0;
    end else if (good) begin
      ref_vld <= 1'b1;
      seq_ref <= seq_cap;
    end
  end
`else
  assign mis = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_data <= '0;
      r_isk <= '0;
      r_cerr <= '0;
      g12 <= '0;
      g34 <= '0;
      seq_cap <= '0;
      hdr_ok <= 1'b0;
      live <= 1'b0;
      cerr_acc <= 1'b0;
      isk_acc <= 1'b0;
      valid <= 1'b0;
      bad_frm <= 1'b0;
      seq_err <= 1'b0;
      rcv_data <= '0;
      frm_seq <= '0;
      err_cnt <= '0;
    end else begin
      r_data <= rx_data;
      r_isk <= rx_isk;
      r_cerr <= rx_code_err;
      live <= first ? sync_done : frm_live;
      hdr_ok <= first ? hdr : hdr_ok;
      seq_cap <= first ? r_data[15:8] : seq_cap;
      cerr_acc <= first ? |r_cerr : frm_cerr;
      isk_acc <= first ? 1'b0 : frm_isk;
      g12 <= phase == PH_W'(1) ? r_data : g12;
      g34 <= phase == PH_W'(2) ? r_data : g34;
      valid <= good;
      bad_frm <= last & frm_live & frm_cerr;
      seq_err <= good & mis;
      rcv_data <= good ? {r_data, g34, g12} : rcv_data;
      frm_seq <= good ? seq_cap : frm_seq;
      err_cnt <= clr_err ? '0 : (err_inc && !(&err_cnt)) ? err_cnt + ERR_CNT_W'(1) : err_cnt;
    end
  end
endmodule
